// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit. Sequences each instruction over several
// cycles around one shared ALU and one memory port, with a sticky illegal trap.
module multicycle_control_fsm #(
    parameter int unsigned SUPPORT_BNE = 1,
    parameter int unsigned SUPPORT_JAL = 1,
    parameter int unsigned MEM_WAIT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
    // DECODE   | read registers, ALU forms OldPC+imm (branch/jump target)
    // MEMADR   | ALU forms rs1+imm load/store address
    // MEMREAD  | load data access, waits for memory
    // MEMWB    | write load data to rd
    // MEMWRITE | store access, strobe held until memory is ready
    // EXECR    | R-type ALU operation
    // EXECI    | I-type ALU operation
    // ALUWB    | write ALU result to rd
    // BRANCH   | compare rs1/rs2, load PC with target on taken
    // JAL      | PC <= target, ALU forms OldPC+4 for rd
    // ILLEGAL  | trapped; held until reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t cur;
    state_t nxt;
    state_t view;
    logic   rdy;
    logic   bne_ok;
    logic   jal_ok;

    assign rdy    = mem_ready || (MEM_WAIT == 0);
    assign bne_ok = (SUPPORT_BNE != 0);
    assign jal_ok = (SUPPORT_JAL != 0);
    assign state  = cur;

    // While reset is held the outputs already present the FETCH decode.
    assign view = rst ? S_FETCH : cur;

    always_comb begin
        nxt = S_ILLEGAL;
        case (cur)
            S_FETCH:    nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH: begin
                        if (funct3 == 3'b000 || (funct3 == 3'b001 && bne_ok))
                            nxt = S_BRANCH;
                        else
                            nxt = S_ILLEGAL;
                    end
                    OP_JAL:            nxt = jal_ok ? S_JAL : S_ILLEGAL;
                    default:           nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: nxt = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    nxt = S_ALUWB;
            S_EXECI:    nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            default:    nxt = S_ILLEGAL;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        case (view)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_write   = rdy;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                // bne inverts the sense of the zero flag
                pc_write  = zero ^ (funct3[0] & bne_ok);
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            cur     <= nxt;
            illegal <= illegal | (nxt == S_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, hand-written corner
// sequences, and random stimulus against an instruction-path reference model.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [6:0] a_opc, b_opc;
    logic [2:0] a_f3, b_f3;

    logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src;
    logic [3:0] a_state;
    logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_illegal;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src;
    logic [3:0] b_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(a_opc), .funct3(a_f3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(a_pc_write), .adr_src(a_adr_src),
        .mem_write(a_mem_write), .ir_write(a_ir_write), .result_src(a_result_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .imm_src(a_imm_src), .reg_write(a_reg_write), .illegal(a_illegal),
        .state(a_state)
    );

    multicycle_control_fsm #(.SUPPORT_BNE(0), .SUPPORT_JAL(0), .MEM_WAIT(0)) dut_nb (
        .clk(clk), .rst(rst), .opcode(b_opc), .funct3(b_f3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(b_pc_write), .adr_src(b_adr_src),
        .mem_write(b_mem_write), .ir_write(b_ir_write), .result_src(b_result_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .imm_src(b_imm_src), .reg_write(b_reg_write), .illegal(b_illegal),
        .state(b_state)
    );

    logic [19:0] vec_a, vec_b;
    assign vec_a = {a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_result_src,
                    a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src, a_reg_write,
                    a_illegal, a_state};
    assign vec_b = {b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_result_src,
                    b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src, b_reg_write,
                    b_illegal, b_state};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs from the per-state output table.
    function automatic logic [19:0] exp_vec(input int st, input bit r, input bit rdy,
                                            input bit z, input logic [6:0] opc,
                                            input logic [2:0] f3, input bit bne,
                                            input bit ill);
        logic pw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, op, imm;
        logic [3:0] s4;
        int s;
        s4 = st[3:0];
        s = r ? 0 : st;
        {pw, adr, mw, irw, rw} = '0;
        {rs, sa, sb, op} = '0;
        case (s)
            0:  begin sb = 2; rs = 2; irw = rdy; pw = rdy; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; op = 2; end
            7:  begin sa = 2; sb = 1; op = 2; end
            8:  rw = 1;
            9:  begin sa = 2; op = 1; pw = z ^ (f3[0] & bne); end
            10: begin sa = 1; sb = 2; pw = 1; end
            default: ;
        endcase
        if (opc == SW) imm = 1;
        else if (opc == BR) imm = 2;
        else if (opc == JL) imm = 3;
        else imm = 0;
        return {pw, adr, mw, irw, rs, sa, sb, op, imm, rw, ill, s4};
    endfunction

    // Reference model: q holds the remaining path of the current instruction.
    task automatic model_step(inout int q[$], inout bit ill, input bit r, input bit rdy,
                              input logic [6:0] opc, input logic [2:0] f3,
                              input bit bne, input bit jal);
        logic [15:0] p;
        int n, cur;
        if (r) begin
            q.delete(); q.push_back(0); ill = 0;
            return;
        end
        cur = q[0];
        if (cur == 11) return;
        if ((cur == 0 || cur == 3 || cur == 5) && !rdy) return;
        if (cur == 0) begin
            case (opc)
                LW: begin p = 16'h1234; n = 4; end
                SW: begin p = 16'h1250; n = 3; end
                RT: begin p = 16'h1680; n = 3; end
                IT: begin p = 16'h1780; n = 3; end
                BR: begin
                    if (f3 == 0 || (f3 == 1 && bne)) begin p = 16'h1900; n = 2; end
                    else begin p = 16'h1B00; n = 2; end
                end
                JL: begin
                    if (jal) begin p = 16'h1A80; n = 3; end
                    else begin p = 16'h1B00; n = 2; end
                end
                default: begin p = 16'h1B00; n = 2; end
            endcase
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(int'(p[15-4*i -: 4]));
            return;
        end
        void'(q.pop_front());
        if (q.size() == 0) q.push_back(0);
        if (q[0] == 11) ill = 1;
    endtask

    typedef struct {
        logic [6:0] opc; logic [2:0] f3; bit z; bit rdy;
        logic [3:0] st; bit pw; bit irw; bit rw; bit mw; bit adr;
        logic [1:0] rs; logic [1:0] imm;
    } row_t;
    row_t tbl[$];

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [3:0] st, input bit pw,
                         input bit rw, input bit ill);
        @(negedge clk);
        check(name, {a_state, a_pc_write, a_reg_write, a_illegal}, {st, pw, rw, ill});
        step();
    endtask

    int qa[$];
    int qb[$];
    bit ill_a, ill_b;
    logic [6:0] pick_ops [6];

    initial begin
        rst = 1; zero = 0; mem_ready = 1;
        a_opc = LW; a_f3 = 3'd2; b_opc = RT; b_f3 = 3'd0;
        pick_ops = '{LW, SW, RT, IT, BR, JL};

        tbl.push_back('{LW, 3'd2, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd0});
        tbl.push_back('{LW, 3'd2, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0});
        tbl.push_back('{LW, 3'd2, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0});
        tbl.push_back('{LW, 3'd2, 0, 1, 4'd3, 0, 0, 0, 0, 1, 2'd0, 2'd0});
        tbl.push_back('{LW, 3'd2, 0, 1, 4'd4, 0, 0, 1, 0, 0, 2'd1, 2'd0});
        tbl.push_back('{SW, 3'd2, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'd2, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 0, 4'd5, 0, 0, 0, 1, 1, 2'd0, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 0, 4'd5, 0, 0, 0, 1, 1, 2'd0, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 0, 4'd5, 0, 0, 0, 1, 1, 2'd0, 2'd1});
        tbl.push_back('{SW, 3'd2, 0, 1, 4'd5, 0, 0, 0, 1, 1, 2'd0, 2'd1});
        tbl.push_back('{BR, 3'd0, 1, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd2});
        tbl.push_back('{BR, 3'd0, 1, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{BR, 3'd0, 1, 1, 4'd9, 1, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{BR, 3'd0, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd2});
        tbl.push_back('{BR, 3'd0, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{BR, 3'd0, 0, 1, 4'd9, 0, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{BR, 3'd1, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd2});
        tbl.push_back('{BR, 3'd1, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{BR, 3'd1, 0, 1, 4'd9, 1, 0, 0, 0, 0, 2'd0, 2'd2});
        tbl.push_back('{JL, 3'd0, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd3});
        tbl.push_back('{JL, 3'd0, 0, 1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd3});
        tbl.push_back('{JL, 3'd0, 0, 1, 4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd3});
        tbl.push_back('{JL, 3'd0, 0, 1, 4'd8, 0, 0, 1, 0, 0, 2'd0, 2'd3});
        tbl.push_back('{RT, 3'd0, 0, 1, 4'd0, 1, 1, 0, 0, 0, 2'd2, 2'd0});

        do_reset();
        @(negedge clk);
        check("reset_state", {a_state, a_illegal, b_state, b_illegal}, 10'd0);
        step();

        // Directed vector table on the default-parameter instance.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            a_opc = tbl[i].opc; a_f3 = tbl[i].f3; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i),
                  {a_state, a_pc_write, a_ir_write, a_reg_write, a_mem_write,
                   a_adr_src, a_result_src, a_imm_src},
                  {tbl[i].st, tbl[i].pw, tbl[i].irw, tbl[i].rw, tbl[i].mw,
                   tbl[i].adr, tbl[i].rs, tbl[i].imm});
            step();
        end

        // Reset during a MEMREAD stall, mem_ready rising with rst, then R-type.
        do_reset();
        a_opc = LW; a_f3 = 3'd2; mem_ready = 1;
        chk_a("rsr_fetch", 4'd0, 1, 0, 0);
        chk_a("rsr_decode", 4'd1, 0, 0, 0);
        chk_a("rsr_memadr", 4'd2, 0, 0, 0);
        mem_ready = 0;
        chk_a("rsr_stall0", 4'd3, 0, 0, 0);
        chk_a("rsr_stall1", 4'd3, 0, 0, 0);
        rst = 1; mem_ready = 1;
        @(negedge clk);
        check("rsr_during_rst", {a_state, a_pc_write, a_ir_write, a_reg_write, a_adr_src},
              {4'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        step();
        rst = 0; a_opc = RT; a_f3 = 3'd0;
        chk_a("rsr_after_rst", 4'd0, 1, 0, 0);
        chk_a("rt_decode", 4'd1, 0, 0, 0);
        chk_a("rt_execr", 4'd6, 0, 0, 0);
        chk_a("rt_aluwb", 4'd8, 0, 1, 0);
        chk_a("rt_done", 4'd0, 1, 0, 0);

        // bne with SUPPORT_BNE=0 traps; MEM_WAIT=0 ignores mem_ready.
        do_reset();
        b_opc = BR; b_f3 = 3'd1; mem_ready = 0; zero = 0;
        @(negedge clk);
        check("nb_fetch_nowait", {b_state, b_pc_write, b_ir_write}, {4'd0, 1'b1, 1'b1});
        step();
        @(negedge clk);
        check("nb_decode", {b_state, b_illegal}, {4'd1, 1'b0});
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("nb_sticky[%0d]", i),
                  {b_state, b_illegal, b_pc_write, b_reg_write, b_mem_write, b_ir_write},
                  {4'd11, 1'b1, 4'b0000});
            step();
        end
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("nb_rst_clears", {b_state, b_illegal}, {4'd0, 1'b0});

        // Random stimulus against the reference model, both instances.
        do_reset();
        qa.delete(); qa.push_back(0); ill_a = 0;
        qb.delete(); qb.push_back(0); ill_b = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom_range(0, 1));
            if (qa[0] == 0) begin
                a_opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pick_ops[$urandom_range(0, 5)];
                a_f3 = 3'($urandom_range(0, 2));
            end
            if (qb[0] == 0) begin
                b_opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pick_ops[$urandom_range(0, 5)];
                b_f3 = 3'($urandom_range(0, 2));
            end
            @(negedge clk);
            check($sformatf("rnd_a[%0d]", c), 32'(vec_a),
                  32'(exp_vec(qa[0], rst, mem_ready, zero, a_opc, a_f3, 1, ill_a)));
            check($sformatf("rnd_b[%0d]", c), 32'(vec_b),
                  32'(exp_vec(qb[0], rst, 1, zero, b_opc, b_f3, 0, ill_b)));
            @(posedge clk);
            model_step(qa, ill_a, rst, mem_ready, a_opc, a_f3, 1, 1);
            model_step(qb, ill_b, rst, 1, b_opc, b_f3, 0, 0);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
